// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared constants, state type and access helpers for data_mem_ctrl
//
// Purpose : RV32I width codes, controller state encoding, byte-enable patterns
//           and the pure functions that classify and shape a memory access.
// Ports   : none (package)
package data_mem_pkg;

  // RV32I funct3 width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Byte-enable patterns before lane shifting
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // hi_nz: any address bit above the RAM's byte space is set
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] off,
                                      input logic       hi_nz);
    logic e;
    e = hi_nz;
    case (f3)
      F3_B, F3_BU: e = e;
      F3_H, F3_HU: e = e | off[0];
      F3_W:        e = e | (off != 2'b00);
      default:     e = 1'b1;
    endcase
    // unsigned widths have no store form
    if (we && (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W)) begin
      e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B:    be = BE_BYTE << off;
      F3_H:    be = BE_HALF << off;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Replicate the store data across lanes so byteena alone picks the target bytes
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extract.sv
// rtl/data_mem_ctrl_load_extract.sv - lane select and sign/zero extension of RAM read data
//
// Purpose : pick the addressed byte/halfword out of a RAM word and extend it.
// Ports   : mem_q  in  32  raw RAM word
//           addr   in  2   byte offset within the word
//           funct3 in  3   RV32I width code
//           data   out 32  extended load result
module load_extract
  import data_mem_pkg::*;
(
  input  logic [31:0] mem_q,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = mem_q[7:0];
      2'd1:    byte_sel = mem_q[15:8];
      2'd2:    byte_sel = mem_q[23:16];
      default: byte_sel = mem_q[31:24];
    endcase
    // halfwords are 2-aligned, so only addr[1] matters
    half_sel = addr[1] ? mem_q[31:16] : mem_q[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      default: data = mem_q;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store sequencer between RV32I memory stage and a 1-cycle sync RAM
//
// Purpose : accept one byte-addressed request, drive word address / byte enables /
//           replicated store data / write strobe, wait out RAM latency, and return
//           extended load data or a store acknowledgement; reject bad accesses.
// Ports   : clock, reset_n (async active-low)
//           req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  core request
//           rsp_valid/rsp_ready/rsp_rdata/rsp_err                     core response
//           mem_address/mem_byteena/mem_data/mem_wren/mem_q           RAM side
// Option  : DATA_MEM_CTRL_DBG_PORT_EN adds a word-only debug requester (dbg_*)
//           that wins arbitration over the core in IDLE.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [31:0]       dbg_req_addr,
  input  logic [31:0]       dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [31:0]       dbg_rsp_rdata,
  output logic              dbg_rsp_err,
`endif
  output logic [MEM_AW-1:0] mem_address,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  state_e state_q, state_d;

  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [MEM_AW-1:0] mem_address_q, mem_address_d;
  logic [3:0]        mem_byteena_q, mem_byteena_d;
  logic [31:0]       mem_data_q, mem_data_d;

  logic              sel_valid, sel_we;
  logic [2:0]        sel_f3;
  logic [31:0]       sel_addr, sel_wdata;
  logic              accept, acc_err, rsp_hs;
  logic [31:0]       ld_data;

`ifdef DATA_MEM_CTRL_DBG_PORT_EN
  logic gnt_dbg_q, gnt_dbg_d;
`endif

  // Request source selection; debug has fixed priority when present
  always_comb begin
    sel_valid = req_valid;
    sel_we    = req_we;
    sel_f3    = req_funct3;
    sel_addr  = req_addr;
    sel_wdata = req_wdata;
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
    if (dbg_req_valid) begin
      sel_valid = 1'b1;
      sel_we    = dbg_req_we;
      sel_f3    = F3_W;
      sel_addr  = dbg_req_addr;
      sel_wdata = dbg_req_wdata;
    end
`endif
  end

  assign accept  = (state_q == IDLE) && sel_valid;
  assign acc_err = access_err(sel_we, sel_f3, sel_addr[1:0], |sel_addr[31:MEM_AW+2]);

`ifdef DATA_MEM_CTRL_DBG_PORT_EN
  assign rsp_hs = gnt_dbg_q ? dbg_rsp_ready : rsp_ready;
`else
  assign rsp_hs = rsp_ready;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = acc_err ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    // decoded from state so reset drops the strobe without waiting for a clock
    mem_wren  = (state_q == ISSUE) && we_q;
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
    req_ready     = (state_q == IDLE) && !dbg_req_valid;
    dbg_req_ready = (state_q == IDLE);
    rsp_valid     = (state_q == RESP) && !gnt_dbg_q;
    dbg_rsp_valid = (state_q == RESP) && gnt_dbg_q;
`endif
  end

  load_extract u_load_extract (
    .mem_q  (mem_q),
    .addr   (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  // Datapath: RAM-side registers are loaded at accept so they are already
  // valid during ISSUE, and otherwise hold their last values.
  always_comb begin
    we_d          = we_q;
    f3_d          = f3_q;
    off_d         = off_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    mem_address_d = mem_address_q;
    mem_byteena_d = mem_byteena_q;
    mem_data_d    = mem_data_q;
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
    gnt_dbg_d     = gnt_dbg_q;
    if (accept) gnt_dbg_d = dbg_req_valid;
`endif
    if (accept) begin
      we_d        = sel_we;
      f3_d        = sel_f3;
      off_d       = sel_addr[1:0];
      rsp_err_d   = acc_err;
      rsp_rdata_d = 32'h0;
      if (!acc_err) begin
        mem_address_d = sel_addr[MEM_AW+1:2];
        mem_byteena_d = sel_we ? store_be(sel_f3, sel_addr[1:0]) : BE_WORD;
        if (sel_we) mem_data_d = store_data(sel_f3, sel_wdata);
      end
    end
    if (state_q == WAIT) rsp_rdata_d = ld_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q          <= 1'b0;
      f3_q          <= F3_W;
      off_q         <= 2'b00;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      mem_address_q <= '0;
      mem_byteena_q <= BE_WORD;
      mem_data_q    <= 32'h0;
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
      gnt_dbg_q     <= 1'b0;
`endif
    end else begin
      we_q          <= we_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      mem_address_q <= mem_address_d;
      mem_byteena_q <= mem_byteena_d;
      mem_data_q    <= mem_data_d;
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
      gnt_dbg_q     <= gnt_dbg_d;
`endif
    end
  end

  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_address = mem_address_q;
  assign mem_byteena = mem_byteena_q;
  assign mem_data    = mem_data_q;
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
  assign dbg_rsp_rdata = rsp_rdata_q;
  assign dbg_rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl with RAM and reference model
module tb_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q = 32'h0;
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
  logic        dbg_req_valid = 1'b0;
  logic        dbg_req_ready;
  logic        dbg_req_we = 1'b0;
  logic [31:0] dbg_req_addr = 32'h0;
  logic [31:0] dbg_req_wdata = 32'h0;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready = 1'b1;
  logic [31:0] dbg_rsp_rdata;
  logic        dbg_rsp_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  data_mem_ctrl #(.MEM_AW(10)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef DATA_MEM_CTRL_DBG_PORT_EN
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
`endif
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM: address/data/strobe sampled on the edge, q valid after it
  logic [31:0] ram [0:1023];
  always @(posedge clock) begin
    if (mem_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_byteena[i]) ram[mem_address][8*i +: 8] <= mem_data[8*i +: 8];
      end
    end
    mem_q <= ram[mem_address];
  end

  int wren_cnt = 0;
  always @(negedge clock) if (mem_wren) wren_cnt <= wren_cnt + 1;

  // ---------------- behavioural reference model ----------------
  function automatic int sz(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic err_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (a >= 32'h1000) return 1'b1;
    if (sz(f3) == 0) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (int'(a[1:0]) % sz(f3)) != 0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] word, input logic [2:0] f3, input int off);
    logic [31:0] v;
    v = word >> (8 * off);
    if (sz(f3) == 1) begin
      v = v & 32'hff;
      if (f3 == 3'd0 && v[7]) v = v | 32'hffffff00;
    end else if (sz(f3) == 2) begin
      v = v & 32'hffff;
      if (f3 == 3'd1 && v[15]) v = v | 32'hffff0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] word, input logic [31:0] wd,
                                           input logic [2:0] f3, input int off);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < sz(f3); i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input int off);
    return 4'(((1 << sz(f3)) - 1) << off);
  endfunction

  function automatic logic [31:0] rep_of(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % sz(f3)) +: 8];
    return r;
  endfunction

  logic        mdl_busy;
  int          mdl_age, mdl_lat;
  logic [31:0] mdl_rdata;
  logic        mdl_err, mdl_wr;
  logic [9:0]  mdl_maddr;
  logic [3:0]  mdl_mbe;
  logic [31:0] mdl_mdata;
  logic [31:0] mdl_mem [0:1023];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mdl_busy  <= 1'b0;
      mdl_wr    <= 1'b0;
      mdl_maddr <= 10'h0;
      mdl_mbe   <= 4'hf;
      mdl_mdata <= 32'h0;
    end else if (mdl_busy) begin
      if (mdl_age >= mdl_lat && rsp_ready) mdl_busy <= 1'b0;
      else mdl_age <= mdl_age + 1;
    end else if (req_valid) begin
      mdl_busy <= 1'b1;
      mdl_age  <= 1;
      mdl_err  <= err_of(req_we, req_funct3, req_addr);
      mdl_lat  <= err_of(req_we, req_funct3, req_addr) ? 1 : (req_we ? 2 : 3);
      mdl_wr   <= !err_of(req_we, req_funct3, req_addr) && req_we;
      mdl_rdata <= (err_of(req_we, req_funct3, req_addr) || req_we) ? 32'h0 :
                   ld_val(mdl_mem[req_addr[11:2]], req_funct3, int'(req_addr[1:0]));
      if (!err_of(req_we, req_funct3, req_addr)) begin
        mdl_maddr <= req_addr[11:2];
        mdl_mbe   <= req_we ? be_of(req_funct3, int'(req_addr[1:0])) : 4'hf;
        if (req_we) begin
          mdl_mdata <= rep_of(req_wdata, req_funct3);
          mdl_mem[req_addr[11:2]] <= st_merge(mdl_mem[req_addr[11:2]], req_wdata,
                                              req_funct3, int'(req_addr[1:0]));
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    logic exp_rv;
    exp_rv = mdl_busy && (mdl_age >= mdl_lat);
    check("req_ready", req_ready, !mdl_busy);
    check("rsp_valid", rsp_valid, exp_rv);
    check("mem_wren", mem_wren, mdl_busy && mdl_age == 1 && mdl_wr);
    check("mem_address", mem_address, mdl_maddr);
    check("mem_byteena", mem_byteena, mdl_mbe);
    check("mem_data", mem_data, mdl_mdata);
    if (exp_rv) begin
      check("rsp_rdata", rsp_rdata, mdl_rdata);
      check("rsp_err", rsp_err, mdl_err);
    end
  end

  // ---------------- driver ----------------
  logic [9:0]  cap_ma;
  logic [3:0]  cap_be;
  logic [31:0] cap_md;
  logic        cap_wr;

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (n == 20) check("req_ready_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    cap_ma = mem_address; cap_be = mem_byteena; cap_md = mem_data; cap_wr = mem_wren;
    lat = 1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
      @(posedge clock); #1; lat++; n++;
    end
    if (n == 20) check("rsp_timeout", 32'd1, 32'd0);
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      check("busy_req_ready", req_ready, 1'b0);
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("ready_after_hs", req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, w0;
    logic [2:0]  f3;
    logic [31:0] a;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, w0;
    logic [2:0]  f3;
    logic [31:0] a;

    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_mem_wren", mem_wren, 1'b0);
    check("rst_mem_byteena", mem_byteena, 4'hf);
    check("rst_mem_address", mem_address, 10'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // prefill words 0..15 so every later load has known contents
    for (int i = 0; i < 16; i++) txn(1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd, er, lat);

    w0 = wren_cnt;
    txn(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 0, rd, er, lat);
    check("sw_addr", cap_ma, 10'd4);
    check("sw_be", cap_be, 4'b1111);
    check("sw_data", cap_md, 32'hDEADBEEF);
    check("sw_wren", cap_wr, 1'b1);
    check("sw_lat", lat, 2);
    check("sw_err", er, 1'b0);
    check("sw_wren_count", wren_cnt - w0, 1);

    txn(1'b1, 3'd1, 32'h012, 32'h00001234, 0, rd, er, lat);
    check("sh_be", cap_be, 4'b1100);
    check("sh_data", cap_md, 32'h12341234);
    txn(1'b0, 3'd1, 32'h012, 32'h0, 0, rd, er, lat);
    check("lh_data", rd, 32'h00001234);
    check("lh_lat", lat, 3);
    txn(1'b0, 3'd0, 32'h013, 32'h0, 0, rd, er, lat);
    check("lb_data", rd, 32'h00000012);

    txn(1'b1, 3'd2, 32'h010, 32'h80FF0000, 0, rd, er, lat);
    txn(1'b0, 3'd0, 32'h013, 32'h0, 0, rd, er, lat);
    check("lb_neg", rd, 32'hFFFFFF80);
    check("lb_neg_lat", lat, 3);
    txn(1'b0, 3'd4, 32'h013, 32'h0, 0, rd, er, lat);
    check("lbu", rd, 32'h00000080);
    txn(1'b0, 3'd5, 32'h012, 32'h0, 0, rd, er, lat);
    check("lhu", rd, 32'h000080FF);

    w0 = wren_cnt;
    txn(1'b0, 3'd2, 32'h002, 32'h0, 0, rd, er, lat);
    check("lw_mis_err", er, 1'b1);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_rdata", rd, 32'h0);
    txn(1'b1, 3'd1, 32'h001, 32'h5555, 0, rd, er, lat);
    check("sh_mis_err", er, 1'b1);
    txn(1'b0, 3'd3, 32'h000, 32'h0, 0, rd, er, lat);
    check("f3_011_err", er, 1'b1);
    txn(1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, er, lat);
    check("oor_err", er, 1'b1);
    check("oor_lat", lat, 1);
    check("err_no_wren", wren_cnt - w0, 0);

    txn(1'b0, 3'd2, 32'h010, 32'h0, 4, rd, er, lat);
    check("lw_hold", rd, 32'h80FF0000);

    // reset while the load is in WAIT
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h010;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_rsp_err", rsp_err, 1'b0);
    check("mid_rst_mem_address", mem_address, 10'h0);
    check("mid_rst_mem_data", mem_data, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    txn(1'b0, 3'd2, 32'h010, 32'h0, 0, rd, er, lat);
    check("lw_after_rst", rd, 32'h80FF0000);

    // randomized traffic, checked by the compare process against the model
    for (int t = 0; t < 250; t++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + $urandom_range(0, 255);
        1:       a = 32'h80000000 | 32'($urandom_range(0, 63));
        default: a = 32'($urandom_range(0, 63));
      endcase
      txn(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 3), rd, er, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
